// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB protocol state encoding and default bus widths
package apb_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_valid
);

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant     = 1'b0;
        any_valid = |valid;
        if (valid[0] && valid[1]) begin
            grant = ~last_grant;
        end else begin
            grant = valid[1];
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - two-requester APB master with round-robin arbitration
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          req0_valid,
    input  logic          req1_valid,
    input  logic          req0_write,
    input  logic          req1_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic [DW-1:0] req1_wdata,
    output logic          req0_done,
    output logic          req1_done,
    output logic [DW-1:0] req_rdata,
    output logic          req_err,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic          PREADY,
    input  logic [DW-1:0] PRDATA,
    input  logic          PSLVERR
);

    apb_state_t state;
    apb_state_t next_state;
    logic       grant;
    logic       arb_grant;
    logic       any_valid;
    logic       other_valid;
    logic       load;
    logic       win;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (grant),
        .grant      (arb_grant),
        .any_valid  (any_valid)
    );

    assign other_valid = grant ? req0_valid : req1_valid;

    // The served requester is never re-granted on its completion edge.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        win        = grant;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    next_state = SETUP;
                    load       = 1'b1;
                    win        = arb_grant;
                end
            end
            SETUP: next_state = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    if (other_valid) begin
                        next_state = SETUP;
                        load       = 1'b1;
                        win        = ~grant;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The grant register doubles as last-grant for the arbiter.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            grant   <= 1'b1;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            state   <= next_state;
            PSEL    <= (next_state != IDLE);
            PENABLE <= (next_state == ACCESS);
            if (load) begin
                grant  <= win;
                PWRITE <= win ? req1_write : req0_write;
                PADDR  <= win ? req1_addr  : req0_addr;
                PWDATA <= win ? req1_wdata : req0_wdata;
            end
        end
    end

    assign req0_done = (state == ACCESS) && PREADY && !grant;
    assign req1_done = (state == ACCESS) && PREADY &&  grant;
    assign req_rdata = PRDATA;
    assign req_err   = PSLVERR;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb/tb_apb_master_arb.sv - directed self-checking bench for apb_master_arb
module tb_apb_master_arb;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req0_valid, req1_valid, req0_write, req1_write;
    logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic        req0_done, req1_done, req_err;
    logic [31:0] req_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;

    logic [31:0] mem [16];
    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master_arb dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_write(req0_write), .req1_write(req1_write),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_done(req0_done), .req1_done(req1_done),
        .req_rdata(req_rdata), .req_err(req_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    // Minimal register-file slave
    assign PRDATA = mem[PADDR[5:2]];
    always @(posedge PCLK)
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge
    task automatic cyc();
        @(posedge PCLK);
        #2;
    endtask

    task automatic chk_bus(input string tag, input logic sel, input logic en,
                           input logic wr, input logic [31:0] addr);
        check({tag, ".psel"}, PSEL, sel);
        check({tag, ".penable"}, PENABLE, en);
        check({tag, ".pwrite"}, PWRITE, wr);
        check({tag, ".paddr"}, PADDR, addr);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[2] = 32'h55;
        PRESET = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_write = 0; req1_write = 0;
        req0_addr = 0; req1_addr = 0; req0_wdata = 0; req1_wdata = 0;
        PREADY = 1'b1; PSLVERR = 1'b0;
        cyc(); cyc();
        #1;
        // Reset state
        chk_bus("rst", 0, 0, 0, 32'h0);
        check("rst.pwdata", PWDATA, 32'h0);
        check("rst.done0", req0_done, 0);
        check("rst.done1", req1_done, 0);

        // Contention from reset: req0 write 0xA @0, req1 read @8
        req0_valid = 1; req0_write = 1; req0_addr = 32'h0; req0_wdata = 32'hA;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h8;
        PRESET = 1'b0;
        cyc(); #1;
        chk_bus("cont.setup0", 1, 0, 1, 32'h0);
        check("cont.pwdata0", PWDATA, 32'hA);
        cyc(); #1;
        chk_bus("cont.access0", 1, 1, 1, 32'h0);
        check("cont.done0", req0_done, 1);
        check("cont.done1_low", req1_done, 0);
        cyc();
        req0_valid = 0;
        #1;
        chk_bus("cont.setup1", 1, 0, 0, 32'h8);
        check("cont.done1_setup", req1_done, 0);
        cyc(); #1;
        chk_bus("cont.access1", 1, 1, 0, 32'h8);
        check("cont.done1", req1_done, 1);
        check("cont.rdata1", req_rdata, 32'h55);
        check("cont.err1", req_err, 0);
        cyc();
        req1_valid = 0;
        #1;
        check("cont.idle_psel", PSEL, 0);
        check("cont.mem0", mem[0], 32'hA);

        // Single write: req0 addr 0 wdata 10
        req0_valid = 1; req0_write = 1; req0_addr = 32'h0; req0_wdata = 32'd10;
        #1;
        check("wr.idle_psel", PSEL, 0);
        cyc(); #1;
        chk_bus("wr.setup", 1, 0, 1, 32'h0);
        check("wr.pwdata", PWDATA, 32'd10);
        check("wr.done_setup", req0_done, 0);
        cyc(); #1;
        chk_bus("wr.access", 1, 1, 1, 32'h0);
        check("wr.done", req0_done, 1);
        cyc();
        req0_write = 0;
        #1;
        check("wr.idle", PSEL, 0);
        // Read back register 0 through req0
        cyc(); cyc(); #1;
        chk_bus("rb.access", 1, 1, 0, 32'h0);
        check("rb.done", req0_done, 1);
        check("rb.rdata", req_rdata, 32'd10);
        cyc();
        req0_valid = 0;
        cyc();

        // Single read: req1 addr 8
        req1_valid = 1; req1_write = 0; req1_addr = 32'h8;
        cyc(); #1;
        chk_bus("rd.setup", 1, 0, 0, 32'h8);
        cyc(); #1;
        check("rd.done1", req1_done, 1);
        check("rd.done0", req0_done, 0);
        check("rd.rdata", req_rdata, 32'h55);
        check("rd.err", req_err, 0);
        cyc();
        req1_valid = 0;
        cyc();

        // Wait states: req1 write 0x77 @4, three PREADY-low cycles
        req1_valid = 1; req1_write = 1; req1_addr = 32'h4; req1_wdata = 32'h77;
        cyc();
        cyc();
        PREADY = 0;
        #1;
        for (int w = 0; w < 3; w++) begin
            chk_bus("ws.wait", 1, 1, 1, 32'h4);
            check("ws.pwdata", PWDATA, 32'h77);
            check("ws.nodone", req1_done, 0);
            cyc(); #1;
        end
        PREADY = 1;
        #1;
        chk_bus("ws.last", 1, 1, 1, 32'h4);
        check("ws.done", req1_done, 1);
        cyc();
        req1_valid = 0;
        #1;
        check("ws.idle", PSEL, 0);
        check("ws.mem1", mem[1], 32'h77);

        // Slave error at 0xFC, then a clean transfer
        req0_valid = 1; req0_write = 0; req0_addr = 32'hFC;
        cyc(); cyc();
        PSLVERR = 1;
        #1;
        check("err.done0", req0_done, 1);
        check("err.flag", req_err, 1);
        cyc();
        req0_valid = 0; PSLVERR = 0;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h8;
        cyc(); cyc(); #1;
        check("err.next_done1", req1_done, 1);
        check("err.next_flag", req_err, 0);
        cyc();
        req1_valid = 0;
        cyc();

        // Reset mid-ACCESS, then req0 must win the tie
        req0_valid = 1; req0_write = 1; req0_addr = 32'h10; req0_wdata = 32'h99;
        cyc(); cyc();
        PREADY = 0;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h8;
        #1;
        check("rm.in_access", PENABLE, 1);
        PREADY = 1;
        PRESET = 1;
        #1;
        check("rm.psel_async", PSEL, 0);
        check("rm.penable_async", PENABLE, 0);
        check("rm.nodone0", req0_done, 0);
        check("rm.nodone1", req1_done, 0);
        check("rm.paddr", PADDR, 32'h0);
        cyc();
        PRESET = 0;
        cyc(); #1;
        chk_bus("rm.tie0", 1, 0, 1, 32'h10);
        check("rm.mem4", mem[4], 32'h0);
        req0_valid = 0; req1_valid = 0;
        cyc(); cyc(); cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
